// File: rtl/task_regs_pkg.sv
// ----------------------------------------------------------------------------
// task_regs_pkg
// Shared constants and helpers for the task register AXI4-Lite slave:
//   REG_*            byte offsets of the eight 32-bit registers (addr[4:0])
//   CTRL_START_BIT   CTRL bit that requests a test start
//   STATUS_*_BIT     bit positions of done (W1C) and busy (RO) in STATUS
//   AXI_RESP_OKAY    the only response this slave ever returns
//   apply_strb()     merges write data into a register per byte-lane strobe
// ----------------------------------------------------------------------------
package task_regs_pkg;

   localparam int DATA_W = 32;
   localparam int STRB_W = DATA_W / 8;

   localparam logic [4:0] REG_CTRL          = 5'h00;
   localparam logic [4:0] REG_ENABLED_TASKS = 5'h04;
   localparam logic [4:0] REG_NUM_BYTES_IN  = 5'h08;
   localparam logic [4:0] REG_STATUS        = 5'h0C;
   localparam logic [4:0] REG_CURRENT_TASK  = 5'h10;
   localparam logic [4:0] REG_BYTES_OUT     = 5'h14;
   localparam logic [4:0] REG_OUT_COUNT     = 5'h18;
   localparam logic [4:0] REG_SCRATCH       = 5'h1C;

   localparam int CTRL_START_BIT  = 0;
   localparam int STATUS_DONE_BIT = 0;
   localparam int STATUS_BUSY_BIT = 1;

   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

   // Replace only the byte lanes whose strobe is set.
   function automatic logic [DATA_W-1:0] apply_strb(input logic [DATA_W-1:0] old_val,
                                                    input logic [DATA_W-1:0] new_val,
                                                    input logic [STRB_W-1:0] strb);
      logic [DATA_W-1:0] res;
      res = old_val;
      for (int i = 0; i < STRB_W; i++) begin
         if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/task_regs_axil_slave_if.sv
// ----------------------------------------------------------------------------
// task_regs_axil_slave_if
// AXI4-Lite bus bundle between the interconnect (master) and the task
// register file (slave). Five channels: AW, W, B, AR, R. No clock/reset
// inside; those stay plain ports on the modules.
// ----------------------------------------------------------------------------
interface task_regs_axil_slave_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic                    arvalid;
   logic                    arready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rvalid;
   logic                    rready;

   modport slave (
      input  awaddr, awvalid, output awready,
      input  wdata, wstrb, wvalid, output wready,
      output bresp, bvalid, input  bready,
      input  araddr, arvalid, output arready,
      output rdata, rresp, rvalid, input  rready
   );

   modport master (
      output awaddr, awvalid, input  awready,
      output wdata, wstrb, wvalid, input  wready,
      input  bresp, bvalid, output bready,
      output araddr, arvalid, input  arready,
      input  rdata, rresp, rvalid, output rready
   );
endinterface

// File: rtl/task_regs_axil_slave.sv
// ----------------------------------------------------------------------------
// task_regs_axil_slave
// AXI4-Lite register file sitting between the interconnect and the task
// engine. Holds task configuration, issues a one-cycle start pulse, and
// captures engine status for readback.
// Ports:
//   s_axi_aclk / s_axi_aresetn   clock, asynchronous active-low reset
//   s_axi                        AXI4-Lite slave bundle (AW, W, B, AR, R)
//   enabled_tasks                task enable mask (ENABLED_TASKS register)
//   num_bytes_in_to_task         byte count for tasks (NUM_BYTES_IN register)
//   start_tests                  one-cycle pulse after a CTRL start write
//   current_task_number          engine task index, sampled on AR handshake
//   tasks_done                   pulse: all enabled tasks finished
//   num_bytes_out_from_task(_valid)  result byte count and its qualifier
// ----------------------------------------------------------------------------
module task_regs_axil_slave
   import task_regs_pkg::*;
#(
   parameter int S_AXI_ADDR_WIDTH = 32,
   parameter int S_AXI_DATA_WIDTH = 32
) (
   input  logic                  s_axi_aclk,
   input  logic                  s_axi_aresetn,
   task_regs_axil_slave_if.slave s_axi,
   output logic [DATA_W-1:0]     enabled_tasks,
   output logic [DATA_W-1:0]     num_bytes_in_to_task,
   output logic                  start_tests,
   input  logic [DATA_W-1:0]     current_task_number,
   input  logic                  tasks_done,
   input  logic [DATA_W-1:0]     num_bytes_out_from_task,
   input  logic                  num_bytes_out_from_task_valid
);

   // Only addr[4:0] is decoded, addr[1:0] ignored; the rest of the address aliases.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{s_axi.awaddr[S_AXI_ADDR_WIDTH-1:5], s_axi.awaddr[1:0],
                               s_axi.araddr[S_AXI_ADDR_WIDTH-1:5], s_axi.araddr[1:0]};

   logic                    rst_done;
   logic                    aw_held, w_held;
   logic [2:0]              aw_word_q;
   logic [S_AXI_DATA_WIDTH-1:0] w_data_q;
   logic [STRB_W-1:0]       w_strb_q;
   logic                    bvalid_q, rvalid_q;
   logic [DATA_W-1:0]       rdata_q;
   logic                    done_q, busy_q;
   logic [DATA_W-1:0]       bytes_out_q, out_count_q, scratch_q;

   logic                    awready, wready, arready;
   logic                    aw_fire, w_fire, ar_fire, wr_en;
   logic [4:0]              wr_off;
   logic [DATA_W-1:0]       wr_data;
   logic [STRB_W-1:0]       wr_strb;
   logic                    start_req, done_clr;
   logic [DATA_W-1:0]       rd_mux;

   // Handshake decode. A write commits on the edge where both halves are
   // available, either held from an earlier cycle or arriving now.
   // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
   always_comb begin
      awready   = rst_done & ~aw_held & ~bvalid_q;
      wready    = rst_done & ~w_held  & ~bvalid_q;
      arready   = rst_done & ~rvalid_q;
      aw_fire   = s_axi.awvalid & awready;
      w_fire    = s_axi.wvalid  & wready;
      ar_fire   = s_axi.arvalid & arready;
      wr_en     = (aw_held | aw_fire) & (w_held | w_fire);
      wr_off    = {(aw_held ? aw_word_q : s_axi.awaddr[4:2]), 2'b00};
      wr_data   = w_held ? w_data_q : s_axi.wdata;
      wr_strb   = w_held ? w_strb_q : s_axi.wstrb;
      start_req = wr_en & (wr_off == REG_CTRL)   & wr_strb[0] & wr_data[CTRL_START_BIT];
      done_clr  = wr_en & (wr_off == REG_STATUS) & wr_strb[0] & wr_data[STATUS_DONE_BIT];
   end

   always_comb begin
      rd_mux = '0;
      case ({s_axi.araddr[4:2], 2'b00})
         REG_ENABLED_TASKS: rd_mux = enabled_tasks;
         REG_NUM_BYTES_IN:  rd_mux = num_bytes_in_to_task;
         REG_STATUS: begin
            rd_mux[STATUS_DONE_BIT] = done_q;
            rd_mux[STATUS_BUSY_BIT] = busy_q;
         end
         REG_CURRENT_TASK:  rd_mux = current_task_number;
         REG_BYTES_OUT:     rd_mux = bytes_out_q;
         REG_OUT_COUNT:     rd_mux = out_count_q;
         REG_SCRATCH:       rd_mux = scratch_q;
         default:           rd_mux = '0;   // CTRL is write-only
      endcase
   end

   // Readiness is held off until the first edge after reset release.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) rst_done <= 1'b0;
      else                rst_done <= 1'b1;
   end

   // Write channel: AW and W are captured independently and held until the
   // partner arrives; bvalid blocks further writes until the response is taken.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         aw_held   <= 1'b0;
         w_held    <= 1'b0;
         aw_word_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         bvalid_q  <= 1'b0;
      end else begin
         if (wr_en) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            bvalid_q <= 1'b1;
         end else begin
            if (aw_fire) begin
               aw_held   <= 1'b1;
               aw_word_q <= s_axi.awaddr[4:2];
            end
            if (w_fire) begin
               w_held   <= 1'b1;
               w_data_q <= s_axi.wdata;
               w_strb_q <= s_axi.wstrb;
            end
            if (bvalid_q && s_axi.bready) bvalid_q <= 1'b0;
         end
      end
   end

   // Register file and task status. Start beats tasks_done; tasks_done beats W1C.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         enabled_tasks        <= '0;
         num_bytes_in_to_task <= '0;
         scratch_q            <= '0;
         start_tests          <= 1'b0;
         done_q               <= 1'b0;
         busy_q               <= 1'b0;
         bytes_out_q          <= '0;
         out_count_q          <= '0;
      end else begin
         if (wr_en) begin
            case (wr_off)
               REG_ENABLED_TASKS: enabled_tasks        <= apply_strb(enabled_tasks, wr_data, wr_strb);
               REG_NUM_BYTES_IN:  num_bytes_in_to_task <= apply_strb(num_bytes_in_to_task, wr_data, wr_strb);
               REG_SCRATCH:       scratch_q            <= apply_strb(scratch_q, wr_data, wr_strb);
               default: ;   // CTRL/STATUS handled below, RO offsets ignored
            endcase
         end

         start_tests <= start_req;
         if (start_req) begin
            busy_q <= 1'b1;
            done_q <= 1'b0;
         end else if (tasks_done) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
         end else if (done_clr) begin
            done_q <= 1'b0;
         end

         if (num_bytes_out_from_task_valid) bytes_out_q <= num_bytes_out_from_task;
         if (start_req)
            out_count_q <= '0;
         else if (num_bytes_out_from_task_valid && (out_count_q != '1))
            out_count_q <= out_count_q + 1'b1;
      end
   end

   // Read channel: data registered on the AR handshake and held until rready.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else if (ar_fire) begin
         rvalid_q <= 1'b1;
         rdata_q  <= rd_mux;
      end else if (rvalid_q && s_axi.rready) begin
         rvalid_q <= 1'b0;
      end
   end

   assign s_axi.awready = awready;
   assign s_axi.wready  = wready;
   assign s_axi.arready = arready;
   assign s_axi.bvalid  = bvalid_q;
   assign s_axi.bresp   = AXI_RESP_OKAY;
   assign s_axi.rvalid  = rvalid_q;
   assign s_axi.rdata   = rdata_q;
   assign s_axi.rresp   = AXI_RESP_OKAY;

endmodule

// File: tb/tb_task_regs_axil_slave.sv
// ----------------------------------------------------------------------------
// tb_task_regs_axil_slave
// Self-checking bench: directed scenarios followed by randomized AXI-Lite
// traffic and engine events, compared against a register-level model.
// ----------------------------------------------------------------------------
module tb_task_regs_axil_slave;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] current_task_number = '0;
   logic        tasks_done = 1'b0;
   logic [31:0] num_bytes_out_from_task = '0;
   logic        num_bytes_out_from_task_valid = 1'b0;
   logic [31:0] enabled_tasks, num_bytes_in_to_task;
   logic        start_tests;

   int n_tests = 0;
   int n_fail  = 0;

   task_regs_axil_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s_axi ();

   task_regs_axil_slave dut (
      .s_axi_aclk                    (clk),
      .s_axi_aresetn                 (rst_n),
      .s_axi                         (s_axi),
      .enabled_tasks                 (enabled_tasks),
      .num_bytes_in_to_task          (num_bytes_in_to_task),
      .start_tests                   (start_tests),
      .current_task_number           (current_task_number),
      .tasks_done                    (tasks_done),
      .num_bytes_out_from_task       (num_bytes_out_from_task),
      .num_bytes_out_from_task_valid (num_bytes_out_from_task_valid)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   logic [31:0] m_regs [8];   // indexed by word offset; only RW/status words used
   logic        m_done, m_busy;

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_regs[i] = '0;
      m_done = 1'b0;
      m_busy = 1'b0;
   endtask

   function automatic logic [31:0] lane_mask(input logic [3:0] strb);
      return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
   endfunction

   // Apply one committed write (and a coincident tasks_done) to the model.
   // Returns 1 when the write requests a start.
   function automatic bit model_write(input logic [31:0] addr, input logic [31:0] data,
                                      input logic [3:0] strb, input bit tdone);
      int  idx = int'(addr[4:2]);
      bit  start = (idx == 0) && strb[0] && data[0];
      bit  clr   = (idx == 3) && strb[0] && data[0];
      logic [31:0] mask = lane_mask(strb);
      if (idx == 1 || idx == 2 || idx == 7)
         m_regs[idx] = (m_regs[idx] & ~mask) | (data & mask);
      if (start) begin
         m_busy = 1'b1; m_done = 1'b0; m_regs[6] = '0;
      end else if (tdone) begin
         m_busy = 1'b0; m_done = 1'b1;
      end else if (clr) begin
         m_done = 1'b0;
      end
      return start;
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] addr);
      case (int'(addr[4:2]))
         0:       return 32'h0;
         3:       return {30'h0, m_busy, m_done};
         4:       return current_task_number;
         default: return m_regs[int'(addr[4:2])];
      endcase
   endfunction

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- bus tasks ----------------
   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly, input bit done_same);
      bit aw_ok = 0, w_ok = 0, aw_f, w_f, exp_start = 0;
      int cyc = 0;
      int last = (aw_dly > w_dly) ? aw_dly : w_dly;
      while (!(aw_ok && w_ok) && cyc < 40) begin
         @(negedge clk);
         s_axi.awaddr  = addr;
         s_axi.awvalid = !aw_ok && (cyc >= aw_dly);
         s_axi.wdata   = data;
         s_axi.wstrb   = strb;
         s_axi.wvalid  = !w_ok && (cyc >= w_dly);
         tasks_done    = done_same && (cyc == last);
         aw_f = s_axi.awvalid && s_axi.awready;
         w_f  = s_axi.wvalid && s_axi.wready;
         if ((aw_ok || aw_f) && (w_ok || w_f))
            exp_start = model_write(addr, data, strb, tasks_done);
         else if (tasks_done) begin
            m_done = 1'b1; m_busy = 1'b0;
         end
         @(posedge clk);
         aw_ok = aw_ok || aw_f;
         w_ok  = w_ok || w_f;
         cyc++;
      end
      @(negedge clk);
      s_axi.awvalid = 1'b0;
      s_axi.wvalid  = 1'b0;
      tasks_done    = 1'b0;
      check("write_accepted", {31'h0, aw_ok && w_ok}, 32'h1);
      check("bvalid_after_commit", {31'h0, s_axi.bvalid}, 32'h1);
      check("bresp", {30'h0, s_axi.bresp}, 32'h0);
      check("start_pulse", {31'h0, start_tests}, {31'h0, exp_start});
      s_axi.bready = (b_dly == 0);
      for (int i = 0; i < b_dly; i++) begin
         check("bvalid_held", {31'h0, s_axi.bvalid}, 32'h1);
         check("awready_blocked", {31'h0, s_axi.awready}, 32'h0);
         check("wready_blocked", {31'h0, s_axi.wready}, 32'h0);
         @(negedge clk);
         if (i == 0) check("start_one_cycle", {31'h0, start_tests}, 32'h0);
      end
      s_axi.bready = 1'b1;
      @(negedge clk);
      if (b_dly == 0) check("start_one_cycle", {31'h0, start_tests}, 32'h0);
      s_axi.bready = 1'b0;
      check("bvalid_cleared", {31'h0, s_axi.bvalid}, 32'h0);
   endtask

   task automatic axi_read(input logic [31:0] addr, input int r_dly, output logic [31:0] got);
      bit ok = 0;
      int cyc = 0;
      logic [31:0] exp = '0;
      while (!ok && cyc < 40) begin
         @(negedge clk);
         s_axi.araddr  = addr;
         s_axi.arvalid = 1'b1;
         current_task_number = $urandom;
         if (s_axi.arready) begin
            exp = model_read(addr);
            ok  = 1;
         end
         @(posedge clk);
         cyc++;
      end
      @(negedge clk);
      s_axi.arvalid = 1'b0;
      current_task_number = $urandom;   // must not affect the captured value
      check("read_accepted", {31'h0, ok}, 32'h1);
      check("rvalid", {31'h0, s_axi.rvalid}, 32'h1);
      check("rresp", {30'h0, s_axi.rresp}, 32'h0);
      check("rdata", s_axi.rdata, exp);
      for (int i = 0; i < r_dly; i++) begin
         @(negedge clk);
         check("rdata_stable", s_axi.rdata, exp);
      end
      got = s_axi.rdata;
      s_axi.rready = 1'b1;
      @(negedge clk);
      s_axi.rready = 1'b0;
      check("rvalid_cleared", {31'h0, s_axi.rvalid}, 32'h0);
   endtask

   task automatic pulse_done();
      @(negedge clk);
      tasks_done = 1'b1;
      m_done = 1'b1;
      m_busy = 1'b0;
      @(negedge clk);
      tasks_done = 1'b0;
   endtask

   task automatic pulse_bytes(input logic [31:0] v);
      @(negedge clk);
      num_bytes_out_from_task = v;
      num_bytes_out_from_task_valid = 1'b1;
      m_regs[5] = v;
      if (m_regs[6] != 32'hFFFF_FFFF) m_regs[6] = m_regs[6] + 1;
      @(negedge clk);
      num_bytes_out_from_task_valid = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] rd, a;
      logic [2:0]  idx;
      int          op;

      s_axi.awaddr = '0; s_axi.awvalid = 0; s_axi.wdata = '0; s_axi.wstrb = '0;
      s_axi.wvalid = 0;  s_axi.bready = 0;  s_axi.araddr = '0; s_axi.arvalid = 0;
      s_axi.rready = 0;
      model_reset();

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_awready", {31'h0, s_axi.awready}, 32'h0);
      check("rst_arready", {31'h0, s_axi.arready}, 32'h0);
      check("rst_bvalid", {31'h0, s_axi.bvalid}, 32'h0);
      check("rst_rvalid", {31'h0, s_axi.rvalid}, 32'h0);
      check("rst_start", {31'h0, start_tests}, 32'h0);
      check("rst_enabled", enabled_tasks, 32'h0);
      check("rst_rdata", s_axi.rdata, 32'h0);
      rst_n = 1'b1;
      #1 check("ready_before_first_edge", {31'h0, s_axi.awready}, 32'h0);
      @(negedge clk);
      check("ready_after_first_edge", {30'h0, s_axi.awready, s_axi.arready}, 32'h3);

      // 1) AW/W same cycle
      axi_write(32'h04, 32'hA5A5_0F0F, 4'hF, 0, 0, 0, 0);
      axi_read(32'h04, 0, rd);
      check("t1_readback", rd, 32'hA5A5_0F0F);
      check("t1_port", enabled_tasks, 32'hA5A5_0F0F);

      // 2) W three cycles ahead of AW, bready low four cycles
      axi_write(32'h1C, 32'h1234_5678, 4'hF, 3, 0, 4, 0);
      axi_read(32'h1C, 2, rd);
      check("t2_readback", rd, 32'h1234_5678);

      // 3) byte-lane write
      axi_write(32'h08, 32'h1111_1111, 4'hF, 0, 0, 0, 0);
      axi_write(32'h08, 32'h0000_3400, 4'b0010, 1, 0, 1, 0);
      axi_read(32'h08, 0, rd);
      check("t3_readback", rd, 32'h1111_3411);
      check("t3_port", num_bytes_in_to_task, 32'h1111_3411);

      // 4) start pulse, busy, done
      axi_write(32'h00, 32'h1, 4'h1, 0, 0, 0, 0);
      axi_read(32'h0C, 0, rd);
      check("t4_status_busy", rd, 32'h2);
      axi_read(32'h00, 0, rd);
      check("t4_ctrl_reads_zero", rd, 32'h0);
      pulse_done();
      axi_read(32'h0C, 0, rd);
      check("t4_status_done", rd, 32'h1);

      // 5) capture counting and W1C vs tasks_done
      axi_write(32'h00, 32'h1, 4'hF, 0, 0, 0, 0);
      pulse_bytes(7); pulse_bytes(9); pulse_bytes(11);
      axi_read(32'h14, 0, rd);
      check("t5_bytes_out", rd, 32'd11);
      axi_read(32'h18, 0, rd);
      check("t5_out_count", rd, 32'd3);
      axi_write(32'h0C, 32'h1, 4'h1, 0, 0, 0, 1);
      axi_read(32'h0C, 0, rd);
      check("t5_done_set_wins", rd, 32'h1);
      axi_write(32'h0C, 32'h1, 4'h1, 0, 0, 0, 0);
      axi_read(32'h0C, 0, rd);
      check("t5_done_w1c", rd, 32'h0);
      axi_write(32'h14, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0);
      axi_read(32'h14, 0, rd);
      check("t5_ro_ignored", rd, 32'd11);

      // Randomized traffic against the model
      for (int n = 0; n < 120; n++) begin
         op  = $urandom_range(0, 9);
         idx = 3'($urandom_range(0, 7));
         a   = ($urandom & 32'hFFFF_FFE0) | {27'h0, idx, 2'b00} | 32'($urandom_range(0, 3));
         if (op < 4)
            axi_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
         else if (op < 8)
            axi_read(a, $urandom_range(0, 3), rd);
         else if (op == 8)
            pulse_done();
         else
            pulse_bytes($urandom);
      end
      check("rand_enabled_port", enabled_tasks, m_regs[1]);
      check("rand_nbytes_port", num_bytes_in_to_task, m_regs[2]);

      // 6) reset with a pending response on both channels
      @(negedge clk);
      s_axi.awaddr = 32'h04; s_axi.awvalid = 1; s_axi.wdata = 32'h5; s_axi.wstrb = 4'hF; s_axi.wvalid = 1;
      s_axi.araddr = 32'h1C; s_axi.arvalid = 1;
      @(negedge clk);
      s_axi.awvalid = 0; s_axi.wvalid = 0; s_axi.arvalid = 0;
      check("t6_pending", {30'h0, s_axi.bvalid, s_axi.rvalid}, 32'h3);
      #2 rst_n = 1'b0;
      #1 check("t6_valids_drop", {30'h0, s_axi.bvalid, s_axi.rvalid}, 32'h0);
      check("t6_ready_drop", {29'h0, s_axi.awready, s_axi.wready, s_axi.arready}, 32'h0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      #1 check("t6_ready_held", {31'h0, s_axi.arready}, 32'h0);
      @(negedge clk);
      check("t6_ready_back", {29'h0, s_axi.awready, s_axi.wready, s_axi.arready}, 32'h7);
      axi_read(32'h04, 0, rd);
      check("t6_reg_reset", rd, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
